// File: rtl/main_memory_hs.sv
// Word-organised main memory with a fixed wait-state handshake.
// A request is captured in IDLE, waits MEM_LATENCY cycles, and then completes in a single ACK cycle.
module main_memory_hs #(
  parameter int DATAWIDTH_BUS      = 32,
  parameter int DATAWIDTH_MEM_ADDR = 10,
  parameter int DATAWIDTH_LATENCY  = 4,
  parameter int MEM_LATENCY        = 2
) (
  input  logic                     MAIN_MEMORY_HS_CLOCK_50,
  input  logic                     MAIN_MEMORY_HS_ResetInLow_In,
  input  logic [DATAWIDTH_BUS-1:0] MAIN_MEMORY_HS_A_InBus,
  input  logic [DATAWIDTH_BUS-1:0] MAIN_MEMORY_HS_B_InBus,
  input  logic                     MAIN_MEMORY_HS_RD_In,
  input  logic                     MAIN_MEMORY_HS_WRMain_In,
  output logic [DATAWIDTH_BUS-1:0] MAIN_MEMORY_HS_Data_OutBus,
  output logic                     MAIN_MEMORY_HS_ACK_Out,
  output logic                     MAIN_MEMORY_HS_Busy_Out,
  output logic                     MAIN_MEMORY_HS_Error_Out
);

  // state | meaning
  // IDLE  | waiting for RD or WRMain; captures the request
  // WAIT  | wait-state counter running down; bus inputs ignored
  // ACK   | access committed on entry; ACK high for this one cycle

  localparam int DEPTH = 1 << DATAWIDTH_MEM_ADDR;
  localparam logic [DATAWIDTH_LATENCY-1:0] LAT_LOAD = DATAWIDTH_LATENCY'(MEM_LATENCY);
  localparam logic [DATAWIDTH_LATENCY-1:0] LAT_ONE  = DATAWIDTH_LATENCY'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_t;

  state_t state, state_next;
  logic [DATAWIDTH_LATENCY-1:0]  cnt, cnt_next;

  logic [DATAWIDTH_MEM_ADDR-1:0] idx_q;
  logic [DATAWIDTH_BUS-1:0]      wdata_q;
  logic                          rd_q;
  logic                          oor_q;
  logic [DATAWIDTH_BUS-1:0]      data_q;
  logic                          err_q;

  logic [DATAWIDTH_BUS-1:0]      mem [DEPTH];

  logic                          req;
  logic                          capture;
  logic                          commit;
  logic [DATAWIDTH_MEM_ADDR-1:0] in_idx;
  logic                          in_oor;
  logic                          in_mis;
  logic                          in_conf;
  logic [DATAWIDTH_MEM_ADDR-1:0] acc_idx;
  logic [DATAWIDTH_BUS-1:0]      acc_wdata;
  logic                          acc_rd;
  logic                          acc_oor;

  assign req     = MAIN_MEMORY_HS_RD_In | MAIN_MEMORY_HS_WRMain_In;
  assign capture = (state == S_IDLE) && req;
  assign in_idx  = MAIN_MEMORY_HS_A_InBus[DATAWIDTH_MEM_ADDR+1:2];
  assign in_oor  = |MAIN_MEMORY_HS_A_InBus[DATAWIDTH_BUS-1:DATAWIDTH_MEM_ADDR+2];
  assign in_mis  = |MAIN_MEMORY_HS_A_InBus[1:0];
  assign in_conf = MAIN_MEMORY_HS_RD_In & MAIN_MEMORY_HS_WRMain_In;

  // With zero latency the ACK-entry edge is the capture edge itself, so the
  // access must come straight from the bus rather than from the latches.
  always_comb begin
    acc_idx   = idx_q;
    acc_wdata = wdata_q;
    acc_rd    = rd_q;
    acc_oor   = oor_q;
    if (state == S_IDLE) begin
      acc_idx   = in_idx;
      acc_wdata = MAIN_MEMORY_HS_B_InBus;
      acc_rd    = MAIN_MEMORY_HS_RD_In;
      acc_oor   = in_oor;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      S_IDLE: begin
        if (req) begin
          cnt_next   = LAT_LOAD;
          state_next = (MEM_LATENCY == 0) ? S_ACK : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt <= LAT_ONE) begin
          cnt_next   = '0;
          state_next = S_ACK;
        end else begin
          cnt_next = cnt - LAT_ONE;
        end
      end
      S_ACK: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign commit = (state_next == S_ACK);

  always_ff @(posedge MAIN_MEMORY_HS_CLOCK_50) begin
    if (!MAIN_MEMORY_HS_ResetInLow_In) begin
      state   <= S_IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      oor_q   <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (capture) begin
        idx_q   <= in_idx;
        wdata_q <= MAIN_MEMORY_HS_B_InBus;
        rd_q    <= MAIN_MEMORY_HS_RD_In;
        oor_q   <= in_oor;
        if (in_oor || in_mis || in_conf) begin
          err_q <= 1'b1;
        end
      end
      if (commit && acc_rd) begin
        data_q <= acc_oor ? '0 : mem[acc_idx];
      end
    end
  end

  // Array has no reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge MAIN_MEMORY_HS_CLOCK_50) begin
    if (MAIN_MEMORY_HS_ResetInLow_In && commit && !acc_rd && !acc_oor) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  assign MAIN_MEMORY_HS_Data_OutBus = data_q;
  assign MAIN_MEMORY_HS_ACK_Out     = (state == S_ACK);
  assign MAIN_MEMORY_HS_Busy_Out    = (state != S_IDLE);
  assign MAIN_MEMORY_HS_Error_Out   = err_q;

endmodule

// File: tb/tb_main_memory_hs.sv
// Directed bench for main_memory_hs: a MEM_LATENCY=2 instance for the main tests
// and a MEM_LATENCY=0 instance for the zero-wait case.
module tb_main_memory_hs;

  logic        clk;
  logic        rst_b, rd, wr;
  logic [31:0] a, b, data;
  logic        ack, busy, err;

  logic        rst0_b, rd0, wr0;
  logic [31:0] a0, b0, data0;
  logic        ack0, busy0, err0;

  int errors = 0;
  int checks = 0;

  main_memory_hs #(.MEM_LATENCY(2)) dut (
    .MAIN_MEMORY_HS_CLOCK_50      (clk),
    .MAIN_MEMORY_HS_ResetInLow_In (rst_b),
    .MAIN_MEMORY_HS_A_InBus       (a),
    .MAIN_MEMORY_HS_B_InBus       (b),
    .MAIN_MEMORY_HS_RD_In         (rd),
    .MAIN_MEMORY_HS_WRMain_In     (wr),
    .MAIN_MEMORY_HS_Data_OutBus   (data),
    .MAIN_MEMORY_HS_ACK_Out       (ack),
    .MAIN_MEMORY_HS_Busy_Out      (busy),
    .MAIN_MEMORY_HS_Error_Out     (err)
  );

  main_memory_hs #(.MEM_LATENCY(0)) dut0 (
    .MAIN_MEMORY_HS_CLOCK_50      (clk),
    .MAIN_MEMORY_HS_ResetInLow_In (rst0_b),
    .MAIN_MEMORY_HS_A_InBus       (a0),
    .MAIN_MEMORY_HS_B_InBus       (b0),
    .MAIN_MEMORY_HS_RD_In         (rd0),
    .MAIN_MEMORY_HS_WRMain_In     (wr0),
    .MAIN_MEMORY_HS_Data_OutBus   (data0),
    .MAIN_MEMORY_HS_ACK_Out       (ack0),
    .MAIN_MEMORY_HS_Busy_Out      (busy0),
    .MAIN_MEMORY_HS_Error_Out     (err0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One request on the latency-2 instance. lat counts cycles after capture
  // until ACK is seen (1 = first cycle after capture); -1 means no ACK.
  task automatic run_txn(input logic r, input logic w, input logic [31:0] addr,
                         input logic [31:0] wd, output int lat, output logic [31:0] rdata,
                         output logic busy1, output logic ack_after);
    lat       = -1;
    rdata     = '0;
    busy1     = 1'b0;
    ack_after = 1'b1;
    a  = addr;
    b  = wd;
    rd = r;
    wr = w;
    @(posedge clk); #1;
    rd = 1'b0;
    wr = 1'b0;
    busy1 = busy;
    for (int k = 1; k <= 20; k++) begin
      if (ack === 1'b1) begin
        lat   = k;
        rdata = data;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    ack_after = ack;
  endtask

  task automatic test_reset();
    int ack_cnt;
    rst_b = 1'b0; rst0_b = 1'b0;
    rd = 0; wr = 0; a = '0; b = '0;
    rd0 = 0; wr0 = 0; a0 = '0; b0 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b1; rst0_b = 1'b1;
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", data); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    ack_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (ack !== 1'b0 || busy !== 1'b0) ack_cnt++;
    end
    checks++; if (ack_cnt !== 0) begin errors++; $display("FAIL idle_no_ack: got %0d active cycles expected 0", ack_cnt); end
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rdata; logic busy1, ack_after;
    run_txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, rdata, busy1, ack_after);
    checks++; if (lat !== 3) begin errors++; $display("FAIL wr_latency: got %0d expected 3", lat); end
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL wr_busy: got %b expected 1", busy1); end
    checks++; if (ack_after !== 1'b0) begin errors++; $display("FAIL wr_ack_width: got %b expected 0", ack_after); end
    checks++; if (data !== 32'h0) begin errors++; $display("FAIL wr_data_hold: got %h expected 0", data); end
    run_txn(1'b1, 1'b0, 32'h10, 32'h0, lat, rdata, busy1, ack_after);
    checks++; if (lat !== 3) begin errors++; $display("FAIL rd_latency: got %0d expected 3", lat); end
    checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got %h expected deadbeef", rdata); end
    checks++; if (ack_after !== 1'b0) begin errors++; $display("FAIL rd_ack_width: got %b expected 0", ack_after); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rd_err: got %b expected 0", err); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rdata; logic busy1, ack_after;
    int first_k, second_k, extra;
    logic [31:0] d1, d2;
    run_txn(1'b0, 1'b1, 32'h14, 32'h55AA55AA, lat, rdata, busy1, ack_after);
    first_k = -1; second_k = -1; extra = 0; d1 = '0; d2 = '0;
    a  = 32'h10;
    rd = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) begin
        if (first_k < 0) begin
          first_k = k; d1 = data;
        end else if (second_k < 0) begin
          second_k = k; d2 = data; rd = 1'b0;
        end else begin
          extra++;
        end
      end else if (first_k >= 0 && second_k < 0 && a == 32'h10) begin
        a = 32'h14;
      end
    end
    rd = 1'b0;
    checks++; if (first_k !== 3) begin errors++; $display("FAIL b2b_first_ack: got cycle %0d expected 3", first_k); end
    checks++; if (d1 !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_first_data: got %h expected deadbeef", d1); end
    checks++; if (second_k !== 7) begin errors++; $display("FAIL b2b_second_ack: got cycle %0d expected 7", second_k); end
    checks++; if (d2 !== 32'h55AA55AA) begin errors++; $display("FAIL b2b_second_data: got %h expected 55aa55aa", d2); end
    checks++; if (extra !== 0) begin errors++; $display("FAIL b2b_extra_ack: got %0d expected 0", extra); end
  endtask

  task automatic test_out_of_range();
    int lat; logic [31:0] rdata; logic busy1, ack_after;
    run_txn(1'b0, 1'b1, 32'h0, 32'h11112222, lat, rdata, busy1, ack_after);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL oor_pre_err: got %b expected 0", err); end
    run_txn(1'b1, 1'b0, 32'h1000, 32'h0, lat, rdata, busy1, ack_after);
    checks++; if (lat !== 3) begin errors++; $display("FAIL oor_rd_latency: got %0d expected 3", lat); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL oor_rd_data: got %h expected 0", rdata); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL oor_err: got %b expected 1", err); end
    run_txn(1'b0, 1'b1, 32'h1000, 32'hFFFFFFFF, lat, rdata, busy1, ack_after);
    checks++; if (lat !== 3) begin errors++; $display("FAIL oor_wr_latency: got %0d expected 3", lat); end
    run_txn(1'b1, 1'b0, 32'h0, 32'h0, lat, rdata, busy1, ack_after);
    checks++; if (rdata !== 32'h11112222) begin errors++; $display("FAIL oor_wr_dropped: got %h expected 11112222", rdata); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL oor_err_sticky: got %b expected 1", err); end
  endtask

  task automatic test_conflict();
    int lat; logic [31:0] rdata; logic busy1, ack_after;
    rst_b = 1'b0;
    @(posedge clk); #1;
    rst_b = 1'b1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b expected 0", err); end
    run_txn(1'b0, 1'b1, 32'h8, 32'hA5A50002, lat, rdata, busy1, ack_after);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL conf_pre_err: got %b expected 0", err); end
    run_txn(1'b1, 1'b1, 32'h8, 32'h1234, lat, rdata, busy1, ack_after);
    checks++; if (rdata !== 32'hA5A50002) begin errors++; $display("FAIL conf_read: got %h expected a5a50002", rdata); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL conf_err: got %b expected 1", err); end
    run_txn(1'b1, 1'b0, 32'h8, 32'h0, lat, rdata, busy1, ack_after);
    checks++; if (rdata !== 32'hA5A50002) begin errors++; $display("FAIL conf_wr_dropped: got %h expected a5a50002", rdata); end
  endtask

  task automatic test_misaligned();
    int lat; logic [31:0] rdata; logic busy1, ack_after;
    rst_b = 1'b0;
    @(posedge clk); #1;
    rst_b = 1'b1;
    run_txn(1'b1, 1'b0, 32'h9, 32'h0, lat, rdata, busy1, ack_after);
    checks++; if (rdata !== 32'hA5A50002) begin errors++; $display("FAIL mis_read: got %h expected a5a50002", rdata); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL mis_err: got %b expected 1", err); end
    run_txn(1'b0, 1'b1, 32'hB, 32'h00000077, lat, rdata, busy1, ack_after);
    run_txn(1'b1, 1'b0, 32'h8, 32'h0, lat, rdata, busy1, ack_after);
    checks++; if (rdata !== 32'h00000077) begin errors++; $display("FAIL mis_write: got %h expected 00000077", rdata); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rdata; logic busy1, ack_after;
    int ack_cnt;
    run_txn(1'b0, 1'b1, 32'h20, 32'h0BADC0DE, lat, rdata, busy1, ack_after);
    a = 32'h20; b = 32'hCAFEF00D; wr = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b expected 1", busy); end
    @(posedge clk); #1;
    rst_b = 1'b0;
    @(posedge clk); #1;
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL mid_ack: got %b expected 0", ack); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_rst: got %b expected 0", busy); end
    checks++; if (data !== 32'h0) begin errors++; $display("FAIL mid_data: got %h expected 0", data); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_err: got %b expected 0", err); end
    rst_b = 1'b1;
    ack_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (ack !== 1'b0) ack_cnt++;
    end
    checks++; if (ack_cnt !== 0) begin errors++; $display("FAIL mid_no_ack: got %0d expected 0", ack_cnt); end
    run_txn(1'b1, 1'b0, 32'h20, 32'h0, lat, rdata, busy1, ack_after);
    checks++; if (rdata !== 32'h0BADC0DE) begin errors++; $display("FAIL mid_mem_kept: got %h expected 0badc0de", rdata); end
  endtask

  task automatic test_latency_zero();
    a0 = 32'h4; b0 = 32'h13579BDF; wr0 = 1'b1;
    @(posedge clk); #1;
    wr0 = 1'b0;
    checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL z_wr_ack: got %b expected 1", ack0); end
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL z_wr_busy: got %b expected 1", busy0); end
    @(posedge clk); #1;
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL z_ack_width: got %b expected 0", ack0); end
    rd0 = 1'b1;
    @(posedge clk); #1;
    rd0 = 1'b0;
    checks++; if (ack0 !== 1'b1) begin errors++; $display("FAIL z_rd_ack: got %b expected 1", ack0); end
    checks++; if (data0 !== 32'h13579BDF) begin errors++; $display("FAIL z_rd_data: got %h expected 13579bdf", data0); end
    @(posedge clk); #1;
    checks++; if (ack0 !== 1'b0) begin errors++; $display("FAIL z_rd_ack_width: got %b expected 0", ack0); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL z_err: got %b expected 0", err0); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_out_of_range();
    test_conflict();
    test_misaligned();
    test_reset_mid();
    test_latency_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/main_memory_hs.md
# main_memory_hs

Word-organised main memory with a wait-state handshake. It serves the microcoded datapath/control pair: it takes the address from the A bus, write data from the B bus, and the RD/WR strobes from control. It returns read data and a one-cycle ACK. Control stalls its microinstruction until ACK, so the block must complete exactly one transaction per request with a deterministic, parameterised latency.

## Interface
- DATAWIDTH_BUS, 32, data/address bus width
- DATAWIDTH_MEM_ADDR, 10, word-index width; array depth is 2^DATAWIDTH_MEM_ADDR words
- DATAWIDTH_LATENCY, 4, width of the wait-state counter
- MEM_LATENCY, 2, wait cycles inserted between request capture and ACK (0 allowed; must fit DATAWIDTH_LATENCY)
- MAIN_MEMORY_HS_CLOCK_50  in  1  system clock, rising edge
- MAIN_MEMORY_HS_ResetInLow_In  in  1  one clock; reset is synchronous and active-low
- MAIN_MEMORY_HS_A_InBus  in  DATAWIDTH_BUS  byte address
- MAIN_MEMORY_HS_B_InBus  in  DATAWIDTH_BUS  write data
- MAIN_MEMORY_HS_RD_In  in  1  read request (level)
- MAIN_MEMORY_HS_WRMain_In  in  1  write request (level)
- MAIN_MEMORY_HS_Data_OutBus  out  DATAWIDTH_BUS  read data, registered
- MAIN_MEMORY_HS_ACK_Out  out  1  transaction complete, one-cycle pulse
- MAIN_MEMORY_HS_Busy_Out  out  1  transaction in progress (WAIT or ACK state)
- MAIN_MEMORY_HS_Error_Out  out  1  sticky: misaligned, out-of-range or RD&WR conflict seen

## Operation
- FSM states: IDLE, WAIT, ACK.
- IDLE: if RD or WRMain is high at a rising edge, latch the address, write data and op type. Load the counter with MEM_LATENCY. Go to WAIT, or directly to ACK if MEM_LATENCY=0.
- WAIT: the counter decrements each cycle. On the edge where it is 1, go to ACK. Bus inputs are ignored while in WAIT.
- Transition into ACK (single edge):
  - Read: Data_OutBus <= mem[word index].
  - Write: mem[word index] <= latched B.
- ACK: ACK_Out=1 for exactly one cycle, then always return to IDLE. A request still asserted in IDLE starts a new transaction. This supports back-to-back microinstructions.
- Word index = A[DATAWIDTH_MEM_ADDR+1:2].
- Misaligned access (A[1:0]≠0):
  - Sets Error.
  - The access proceeds using the truncated word index.
- Out-of-range access (any bit of A above DATAWIDTH_MEM_ADDR+1 set):
  - Sets Error.
  - A read returns 0.
  - A write is dropped.
  - ACK is still given.
- RD and WRMain both high at capture:
  - Sets Error.
  - Performed as a read; the write is dropped.
- Data_OutBus holds its value until the next completed read. Writes do not change it.
- Error is sticky and is cleared only by reset.
- Memory contents are not affected by reset.

## Timing
- Reset (ResetInLow_In=0 at an edge):
  - state=IDLE, counter=0.
  - ACK_Out=0, Busy_Out=0, Data_OutBus=0, Error_Out=0.
- Reset mid-transaction aborts it. A write not yet committed (reset at or before the ACK-entry edge) is never written.
- Latency: request sampled at edge E. ACK is high during the cycle after edge E+MEM_LATENCY (1+MEM_LATENCY cycles after capture). Read data is valid in that same cycle.
- Busy_Out is high from the cycle after capture through the ACK cycle inclusive.
- Minimum request spacing is MEM_LATENCY+2 cycles (capture, waits, ACK, then IDLE capture).
- A request deasserted during WAIT does not cancel the transaction.

## Test plan
- Reset low 2 cycles, then release → all outputs 0, state IDLE; no ACK with RD=WR=0 for 10 cycles.
- MEM_LATENCY=2: write A=0x0000_0010, B=0xDEADBEEF, then read A=0x10 → each ACK 3 cycles after capture, ACK one cycle wide, read returns 0xDEADBEEF, Error=0.
- RD held high continuously, with A changed to 0x14 in the cycle after ACK → second transaction captured in IDLE, ACK 3 cycles later, Data = mem[5].
- Read A=0x0000_1000 (out of range for 10-bit index) → ACK after normal latency, Data=0, Error=1 and stays 1. Write to the same address → mem[0] unchanged.
- RD and WR both high with A=0x8, B=0x1234 → performed as a read, mem[2] unchanged, Error=1. Misaligned read A=0x9 → returns mem[2], Error=1.
- Write A=0x20, B=0xCAFEF00D, with reset asserted during WAIT → no ACK, mem[8] keeps its old value, outputs return to reset values. MEM_LATENCY=0 build → ACK in the cycle right after capture.
